score_text_overlay: RTL

Parametrised text overlay for the VGA pipeline: draws a writable line of `N_CHARS` 8×16 glyphs at a fixed screen origin and outputs a registered 12-bit pixel colour. A sequential binary-to-BCD loader accepts a score through a valid/ready handshake and writes its decimal digits into the rightmost character slots. It sits between the pixel-position generator and the final RGB mux, alongside the game-object renderers.

---
 rtl/text_overlay_pkg.sv | 15 +
 rtl/ascii_rom.sv | 37 +++
 rtl/score_text_overlay.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the score text overlay.
package text_overlay_pkg;

   typedef enum logic [1:0] {
      LD_IDLE    = 2'd0,
      LD_CONVERT = 2'd1,
      LD_WRITE   = 2'd2
   } loader_state_t;

   localparam logic [6:0]  ASCII_SPACE = 7'h20;
   localparam logic [6:0]  ASCII_ZERO  = 7'h30;
   localparam int unsigned GLYPH_W     = 8;
   localparam int unsigned GLYPH_H     = 16;

endpackage

// File: rtl/ascii_rom.sv
// Team font ROM: 2048 x 8, address {char[6:0], row[3:0]}, one-cycle read.
// Glyphs are stored as 16 bytes per character, row 0 in the top byte.
module ascii_rom (
   input  logic        i_clk,
   input  logic [10:0] i_addr,
   output logic [7:0]  o_data
);

   logic [127:0] w_glyph;
   logic [7:0]   r_data;

   // bitmap of the addressed character
   always_comb begin
      case (i_addr[10:4])
         7'h30:   w_glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
         7'h31:   w_glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
         7'h32:   w_glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
         7'h33:   w_glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
         7'h34:   w_glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
         7'h35:   w_glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
         7'h36:   w_glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
         7'h37:   w_glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
         7'h38:   w_glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
         7'h39:   w_glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
         7'h41:   w_glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
         default: w_glyph = '0;
      endcase
   end

   // synchronous read of one glyph row; ~row*8 selects byte 15-row
   always_ff @(posedge i_clk) begin
      r_data <= w_glyph[{~i_addr[3:0], 3'b000} +: 8];
   end

   assign o_data = r_data;

endmodule

// File: rtl/score_text_overlay.sv
// Text overlay: one line of N_CHARS glyphs with a double-dabble score loader
// writing the rightmost N_DIGITS slots; 2-clock registered pixel path.
module score_text_overlay
   import text_overlay_pkg::*;
#(
   parameter int unsigned N_CHARS  = 8,
   parameter int unsigned X0       = 24,
   parameter int unsigned Y0       = 48,
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned SCORE_W  = 14,
   parameter logic [11:0] FG       = 12'hFFF,
   parameter logic [11:0] BG       = 12'h000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       video_on,
   input  logic [9:0]                 x,
   input  logic [9:0]                 y,
   input  logic                       wr_en,
   input  logic [$clog2(N_CHARS)-1:0] wr_idx,
   input  logic [6:0]                 wr_char,
   input  logic                       score_valid,
   input  logic [SCORE_W-1:0]         score,
   output logic                       score_ready,
   output logic [11:0]                rgb
);

   localparam int unsigned     IDX_W    = $clog2(N_CHARS);
   localparam int unsigned     BCD_W    = 4 * N_DIGITS;
   localparam int unsigned     CNT_W    = $clog2(SCORE_W + N_DIGITS + 1);
   localparam longint unsigned MAX_VAL  = (64'd10 ** N_DIGITS) - 64'd1;
   localparam logic [10:0]     X_LO     = 11'(X0);
   localparam logic [10:0]     X_HI     = 11'(X0 + GLYPH_W * N_CHARS);
   localparam logic [10:0]     Y_LO     = 11'(Y0);
   localparam logic [10:0]     Y_HI     = 11'(Y0 + GLYPH_H);
   localparam logic [IDX_W-1:0] DIG_BASE = IDX_W'(N_CHARS - N_DIGITS);

   loader_state_t    r_state, w_state_nxt;
   logic             r_ready;
   logic [SCORE_W-1:0] r_bin, w_score_sat;
   logic [BCD_W-1:0] r_bcd, w_bcd_adj;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept, w_fsm_wr;
   logic [IDX_W-1:0] w_fsm_slot;
   logic [6:0]       w_fsm_char;
   logic [6:0]       r_buf [N_CHARS];

   logic [10:0]      w_x11, w_y11;
   logic             w_in_box;
   logic [IDX_W-1:0] w_slot;
   logic [3:0]       w_row;
   logic [7:0]       w_rom_data;
   logic             r_vid1, r_box1;
   logic [2:0]       r_col1;

   assign score_ready = r_ready;
   assign w_score_sat = (64'(score) > MAX_VAL) ? SCORE_W'(MAX_VAL) : score;
   assign w_fsm_slot  = DIG_BASE + IDX_W'(r_cnt);
   assign w_fsm_char  = ASCII_ZERO + {3'b000, r_bcd[BCD_W-1 -: 4]};

   // add-3 correction of every BCD nibble that is 5 or more
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // loader next state and FSM write strobe
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fsm_wr    = 1'b0;
      case (r_state)
         LD_IDLE: begin
            if (score_valid && r_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = LD_CONVERT;
            end
         end
         LD_CONVERT: begin
            if (r_cnt == CNT_W'(SCORE_W - 1)) w_state_nxt = LD_WRITE;
         end
         LD_WRITE: begin
            w_fsm_wr = 1'b1;
            if (r_cnt == CNT_W'(N_DIGITS - 1)) w_state_nxt = LD_IDLE;
         end
         default: w_state_nxt = LD_IDLE;
      endcase
   end

   // loader state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= LD_IDLE;
      else          r_state <= w_state_nxt;
   end

   // loader datapath: capture, shift-add-3, digit shift-out, ready flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready <= 1'b0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
      end else begin
         r_ready <= (r_state == LD_IDLE) && !w_accept;
         case (r_state)
            LD_IDLE: begin
               if (w_accept) begin
                  r_bin <= w_score_sat;
                  r_bcd <= '0;
                  r_cnt <= '0;
               end
            end
            LD_CONVERT: begin
               r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
               r_bin <= r_bin << 1;
               r_cnt <= (r_cnt == CNT_W'(SCORE_W - 1)) ? '0 : r_cnt + CNT_W'(1);
            end
            LD_WRITE: begin
               r_bcd <= r_bcd << 4;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // character buffer; a loader write takes priority over a direct write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < N_CHARS; i++) r_buf[i] <= ASCII_SPACE;
      end else if (w_fsm_wr) begin
         r_buf[w_fsm_slot] <= w_fsm_char;
      end else if (wr_en) begin
         r_buf[wr_idx] <= wr_char;
      end
   end

   // pixel stage 1 decode; 11-bit compares keep the box edge from wrapping
   assign w_x11    = {1'b0, x};
   assign w_y11    = {1'b0, y};
   assign w_in_box = (w_x11 >= X_LO) && (w_x11 < X_HI) && (w_y11 >= Y_LO) && (w_y11 < Y_HI);
   assign w_slot   = IDX_W'((w_x11 - X_LO) >> 3);
   assign w_row    = 4'(w_y11 - Y_LO);

   ascii_rom u_rom (
      .i_clk  (clk),
      .i_addr ({r_buf[w_slot], w_row}),
      .o_data (w_rom_data)
   );

   // pixel stage 1: controls delayed alongside the ROM read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vid1 <= 1'b0;
         r_box1 <= 1'b0;
         r_col1 <= '0;
      end else begin
         r_vid1 <= video_on;
         r_box1 <= w_in_box;
         r_col1 <= x[2:0];
      end
   end

   // pixel stage 2: colour select into the output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  rgb <= 12'h000;
      else if (!r_vid1)                              rgb <= 12'h000;
      else if (r_box1 && w_rom_data[3'd7 - r_col1]) rgb <= FG;
      else                                           rgb <= BG;
   end

endmodule
